// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel edge-packing stage.
//   WORD_W / MAG_W / CNT_W : packed word width, magnitude width, bit-count width
//   edge_word_t            : one packed output word {data, cnt, last}
//   oreg_state_t           : occupancy state of a single-entry vld/busy register
package sobel_pkg;

  localparam int WORD_W = 32;
  localparam int MAG_W  = 32;
  localparam int CNT_W  = 6;

  typedef struct packed {
    logic [WORD_W-1:0] data;
    logic [CNT_W-1:0]  cnt;
    logic              last;
  } edge_word_t;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } oreg_state_t;

endpackage

// File: rtl/p2p_out_reg.sv
// Single-entry vld/busy holding register with a load-while-drain path.
//   clk, rst_n   : clock, asynchronous active-low reset
//   load         : capture load_data this cycle (caller guarantees the slot is
//                  free or draining)
//   load_data    : payload to capture
//   out_busy     : downstream backpressure
//   out_vld      : payload valid
//   out_data     : payload, held stable while out_vld & out_busy
//   out_accept   : a downstream transfer happens on this edge
module p2p_out_reg
  import sobel_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         out_busy,
  output logic         out_vld,
  output logic [W-1:0] out_data,
  output logic         out_accept
);

  oreg_state_t state_p1, state_nxt;
  logic [W-1:0] data_p1;

  assign out_vld    = (state_p1 == HOLD);
  assign out_accept = out_vld & ~out_busy;
  assign out_data   = data_p1;

  // A load in the same cycle as acceptance keeps the slot occupied, so
  // back-to-back words stream without a bubble.
  always_comb begin
    state_nxt = state_p1;
    case (state_p1)
      RUN:     if (load) state_nxt = HOLD;
      HOLD:    if (out_accept && !load) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // ---- stage p1: output holding register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p1 <= RUN;
      data_p1  <= '0;
    end else begin
      state_p1 <= state_nxt;
      if (load) data_p1 <= load_data;
    end
  end

endmodule

// File: rtl/sobel_edge_packer.sv
// Thresholds a stream of Sobel gradient magnitudes into 1-bit edge flags and
// packs them LSB-first into 32-bit words, flushing a partial word at each row
// end and pulsing o_frame_done once the frame's final word has been taken.
//   i_clk, i_rst              : clock, asynchronous active-low reset
//   i_mag_vld/busy/data       : magnitude input handshake (busy is an output)
//   i_thresh                  : edge threshold, latched at each frame's first pixel
//   o_bits_vld/busy           : packed-word output handshake (busy is an input)
//   o_bits_data/cnt/last      : packed bits, number of valid bits, row-end marker
//   o_frame_done              : one-cycle pulse after the last word of a frame
module sobel_edge_packer
  import sobel_pkg::*;
#(
  parameter int IMG_W = 256,
  parameter int IMG_H = 256,
  parameter int CW    = 12
) (
  input  logic              i_clk,
  input  logic              i_rst,
  output logic              i_mag_busy,
  input  logic              i_mag_vld,
  input  logic [MAG_W-1:0]  i_mag_data,
  input  logic [MAG_W-1:0]  i_thresh,
  input  logic              o_bits_busy,
  output logic              o_bits_vld,
  output logic [WORD_W-1:0] o_bits_data,
  output logic [CNT_W-1:0]  o_bits_cnt,
  output logic              o_bits_last,
  output logic              o_frame_done
);

  logic [WORD_W-1:0] acc_p0;
  logic [4:0]        idx_p0;
  logic [CW-1:0]     col_p0, row_p0;
  logic [MAG_W-1:0]  thresh_p0;
  logic              frame_pend_p1, frame_done_p1;

  logic              in_accept, out_accept, frame_start;
  logic              col_end, row_end, word_close;
  logic [MAG_W-1:0]  thr_eff;
  logic              edge_bit;
  logic [WORD_W-1:0] word_bits;
  edge_word_t        word_nxt, word_p1;

  assign i_mag_busy  = o_bits_vld & o_bits_busy;
  assign in_accept   = i_mag_vld & ~i_mag_busy;

  assign frame_start = (col_p0 == '0) && (row_p0 == '0);
  assign col_end     = (col_p0 == CW'(IMG_W - 1));
  assign row_end     = (row_p0 == CW'(IMG_H - 1));
  assign word_close  = in_accept & ((idx_p0 == 5'd31) | col_end);

  // The first pixel of a frame must see the threshold being latched with it.
  assign thr_eff   = frame_start ? i_thresh : thresh_p0;
  assign edge_bit  = (i_mag_data >= thr_eff);
  assign word_bits = acc_p0 | (WORD_W'(edge_bit) << idx_p0);

  always_comb begin
    word_nxt.data = word_bits;
    word_nxt.cnt  = {1'b0, idx_p0} + CNT_W'(1);
    word_nxt.last = col_end;
  end

  // ---- stage p0: accumulator, counters, threshold latch ----
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      acc_p0    <= '0;
      idx_p0    <= '0;
      col_p0    <= '0;
      row_p0    <= '0;
      thresh_p0 <= '0;
    end else if (in_accept) begin
      if (frame_start) thresh_p0 <= i_thresh;
      if (word_close) begin
        acc_p0 <= '0;
        idx_p0 <= '0;
      end else begin
        acc_p0 <= word_bits;
        idx_p0 <= idx_p0 + 5'd1;
      end
      if (col_end) begin
        col_p0 <= '0;
        row_p0 <= row_end ? '0 : row_p0 + CW'(1);
      end else begin
        col_p0 <= col_p0 + CW'(1);
      end
    end
  end

  // ---- stage p1: packed word output register ----
  p2p_out_reg #(
    .W ($bits(edge_word_t))
  ) u_out_reg (
    .clk        (i_clk),
    .rst_n      (i_rst),
    .load       (word_close),
    .load_data  (word_nxt),
    .out_busy   (o_bits_busy),
    .out_vld    (o_bits_vld),
    .out_data   (word_p1),
    .out_accept (out_accept)
  );

  assign o_bits_data = word_p1.data;
  assign o_bits_cnt  = word_p1.cnt;
  assign o_bits_last = word_p1.last;

  // Pending flag marks that the word now in the output register ends the
  // frame; a new frame-end close wins over clearing so tiny frames still pulse.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      frame_pend_p1 <= 1'b0;
      frame_done_p1 <= 1'b0;
    end else begin
      frame_done_p1 <= frame_pend_p1 & out_accept;
      if (word_close && col_end && row_end) frame_pend_p1 <= 1'b1;
      else if (out_accept)                  frame_pend_p1 <= 1'b0;
    end
  end

  assign o_frame_done = frame_done_p1;

endmodule

// File: tb/tb_sobel_edge_packer.sv
module tb_sobel_edge_packer;

  localparam int W = 40;
  localparam int H = 2;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_mag_busy;
  logic        i_mag_vld;
  logic [31:0] i_mag_data;
  logic [31:0] i_thresh;
  logic        o_bits_busy;
  logic        o_bits_vld;
  logic [31:0] o_bits_data;
  logic [5:0]  o_bits_cnt;
  logic        o_bits_last;
  logic        o_frame_done;

  always #5 i_clk = ~i_clk;

  sobel_edge_packer #(.IMG_W(W), .IMG_H(H), .CW(12)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_mag_busy   (i_mag_busy),
    .i_mag_vld    (i_mag_vld),
    .i_mag_data   (i_mag_data),
    .i_thresh     (i_thresh),
    .o_bits_busy  (o_bits_busy),
    .o_bits_vld   (o_bits_vld),
    .o_bits_data  (o_bits_data),
    .o_bits_cnt   (o_bits_cnt),
    .o_bits_last  (o_bits_last),
    .o_frame_done (o_frame_done)
  );

  // Reference model: words expected in frame order, built from the pixel
  // index within the frame (col = pix % W, row = pix / W).
  typedef struct {
    logic [31:0] data;
    int          cnt;
    bit          last;
    bit          flast;
  } word_t;

  word_t       exp_q[$];
  int          pix;
  logic [31:0] frame_thr;
  logic [31:0] acc_m;
  int          nbits;
  bit          done_exp;

  int checks = 0;
  int errors = 0;
  int done_seen, stall_cycles;
  logic [31:0] log_data[$];
  int          log_cnt[$];
  bit          log_last[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    exp_q.delete();
    pix       = 0;
    frame_thr = '0;
    acc_m     = '0;
    nbits     = 0;
    done_exp  = 1'b0;
  endfunction

  function automatic void model_pixel(input logic [31:0] mag, input logic [31:0] thr_in);
    int    col;
    int    row;
    word_t w;
    col = pix % W;
    row = pix / W;
    if (pix == 0) frame_thr = thr_in;
    if (mag >= frame_thr) acc_m[nbits] = 1'b1;
    nbits++;
    if (nbits == 32 || col == W - 1) begin
      w.data  = acc_m;
      w.cnt   = nbits;
      w.last  = (col == W - 1);
      w.flast = (col == W - 1) && (row == H - 1);
      exp_q.push_back(w);
      acc_m = '0;
      nbits = 0;
    end
    pix = (pix + 1) % (W * H);
  endfunction

  task automatic check_outputs();
    bit ev;
    ev = (exp_q.size() > 0);
    chk("vld", o_bits_vld, ev);
    chk("mag_busy", i_mag_busy, ev && o_bits_busy);
    chk("frame_done", o_frame_done, done_exp);
    if (ev && o_bits_vld) begin
      chk("data", o_bits_data, exp_q[0].data);
      chk("cnt", o_bits_cnt, exp_q[0].cnt);
      chk("last", o_bits_last, exp_q[0].last);
    end
    if (o_frame_done) done_seen++;
  endtask

  // One clock: drive inputs, advance the model to the post-edge state, then
  // compare on the falling edge.
  task automatic cycle(input bit vld, input logic [31:0] mag, input bit obusy, output bit accepted);
    bit    ev;
    bit    in_acc;
    bit    out_acc;
    word_t w;
    i_mag_vld   = vld;
    i_mag_data  = mag;
    o_bits_busy = obusy;
    #1;
    if (vld && i_mag_busy) stall_cycles++;
    if (o_bits_vld && !obusy) begin
      log_data.push_back(o_bits_data);
      log_cnt.push_back(int'(o_bits_cnt));
      log_last.push_back(o_bits_last);
    end
    ev      = (exp_q.size() > 0);
    in_acc  = vld && !(ev && obusy);
    out_acc = ev && !obusy;
    done_exp = 1'b0;
    if (out_acc) begin
      w = exp_q.pop_front();
      done_exp = w.flast;
    end
    if (in_acc) model_pixel(mag, i_thresh);
    accepted = in_acc;
    @(posedge i_clk);
    @(negedge i_clk);
    check_outputs();
  endtask

  // mode 0: alternating 100/99 by pixel index; 1: all ones; 2: random
  task automatic run_pix(input int n, input int mode, input int busy_pct, input int vld_pct);
    int          got;
    int          budget;
    bit          acc;
    bit          v;
    bit          b;
    logic [31:0] m;
    got    = 0;
    budget = n * 20 + 50;
    while (got < n && budget > 0) begin
      case (mode)
        0:       m = (pix % 2 == 0) ? 32'd100 : 32'd99;
        1:       m = 32'hFFFF_FFFF;
        default: m = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 200));
      endcase
      v = ($urandom_range(0, 99) < vld_pct);
      b = ($urandom_range(0, 99) < busy_pct);
      cycle(v, m, b, acc);
      if (acc) got++;
      budget--;
    end
    if (got < n) chk("pixel_budget", 64'(got), 64'(n));
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) cycle(1'b0, 32'd0, 1'b0, acc);
  endtask

  task automatic do_reset();
    #2;
    i_rst     = 1'b0;
    i_mag_vld = 1'b0;
    #1;
    chk("rst_vld", o_bits_vld, 1'b0);
    chk("rst_data", o_bits_data, 32'd0);
    chk("rst_cnt", o_bits_cnt, 6'd0);
    chk("rst_last", o_bits_last, 1'b0);
    chk("rst_done", o_frame_done, 1'b0);
    chk("rst_busy", i_mag_busy, 1'b0);
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b1;
    model_reset();
  endtask

  initial begin
    logic [31:0] held;
    bit          acc;
    int          n0;

    i_rst       = 1'b0;
    i_mag_vld   = 1'b0;
    i_mag_data  = '0;
    i_thresh    = '0;
    o_bits_busy = 1'b0;
    done_seen    = 0;
    stall_cycles = 0;
    model_reset();
    @(negedge i_clk);
    do_reset();
    check_outputs();

    // Alternating 100/99 against threshold 100, one full frame.
    i_thresh = 32'd100;
    log_data.delete(); log_cnt.delete(); log_last.delete();
    done_seen = 0;
    run_pix(W * H, 0, 0, 100);
    idle(3);
    if (log_data.size() >= 2) begin
      chk("alt_w0_data", log_data[0], 32'h5555_5555);
      chk("alt_w0_cnt", log_cnt[0], 32);
      chk("alt_w0_last", log_last[0], 1'b0);
      chk("alt_w1_data", log_data[1], 32'h0000_0055);
      chk("alt_w1_cnt", log_cnt[1], 8);
      chk("alt_w1_last", log_last[1], 1'b1);
    end else begin
      chk("alt_words", log_data.size(), 2);
    end
    chk("alt_done_pulses", done_seen, 1);

    // Backpressure: hold a pending word for 5 cycles with input still offered.
    i_thresh = 32'd50;
    run_pix(20, 2, 30, 80);
    while (exp_q.size() == 0) run_pix(1, 2, 0, 100);
    held = o_bits_data;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 32'd123, 1'b1, acc);
      chk("hold_stable", o_bits_data, held);
      chk("hold_noaccept", acc, 1'b0);
    end
    run_pix(W * H - 20 - (pix == 0 ? W * H - 20 : 0), 2, 30, 80);
    while (pix != 0) run_pix(1, 2, 30, 80);
    idle(3);

    // Full-rate streaming of saturated magnitudes with threshold 0.
    i_thresh = 32'd0;
    log_data.delete(); log_cnt.delete(); log_last.delete();
    done_seen    = 0;
    stall_cycles = 0;
    run_pix(W * H, 1, 0, 100);
    idle(3);
    chk("stream_words", log_data.size(), 4);
    chk("stream_done_pulses", done_seen, 1);
    chk("stream_stalls", stall_cycles, 0);
    if (log_data.size() == 4) begin
      chk("stream_w0", log_data[0], 32'hFFFF_FFFF);
      chk("stream_w1", log_data[1], 32'h0000_00FF);
      chk("stream_last_pattern", {log_last[0], log_last[1], log_last[2], log_last[3]}, 4'b0101);
    end

    // Threshold changed mid-frame must not take effect until the next frame.
    i_thresh = 32'd100;
    run_pix(10, 2, 20, 90);
    i_thresh = 32'd0;
    run_pix(W * H - 10, 2, 20, 90);
    run_pix(W * H, 2, 20, 90);
    idle(3);

    // Reset after 10 pixels of row 0; the next 40 pixels form a fresh row.
    i_thresh = 32'd60;
    run_pix(10, 2, 0, 100);
    do_reset();
    log_data.delete(); log_cnt.delete(); log_last.delete();
    run_pix(W, 2, 0, 100);
    idle(2);
    n0 = log_data.size();
    chk("post_rst_words", n0, 2);
    if (n0 == 2) begin
      chk("post_rst_last", log_last[1], 1'b1);
      chk("post_rst_cnt", log_cnt[1], 8);
    end
    run_pix(W, 2, 0, 100);
    idle(3);

    // Random stress with occasional threshold updates.
    for (int k = 0; k < 12; k++) begin
      i_thresh = 32'($urandom_range(0, 200));
      run_pix(37, 2, 40, 70);
    end
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sobel_edge_packer.md
Name: sobel_edge_packer

Overview:
- Downstream neighbour of the Sobel filter. Consumes its 32-bit per-pixel magnitude stream over the vld/busy point-to-point handshake.
- Thresholds each magnitude into a 1-bit edge flag and packs the flags LSB-first into 32-bit words.
- Flushes a partial word at every row end. Emits a one-cycle frame-done pulse for the host/DMA side.

Parameters:
- IMG_W, 256, pixels per row (1..4095); need not be a multiple of 32.
- IMG_H, 256, rows per frame (1..4095).
- CW, 12, width of the column and row counters; must satisfy 2^CW > max(IMG_W, IMG_H).

Ports:
- i_clk  in  1  clock; all logic on rising edge.
- i_rst  in  1  reset, asynchronous, active-low. Asserting 0 clears all state immediately.
- i_mag_busy  out  1  backpressure to the Sobel output.
- i_mag_vld  in  1  magnitude valid.
- i_mag_data  in  32  unsigned gradient magnitude.
- i_thresh  in  32  unsigned edge threshold; quasi-static.
- o_bits_busy  in  1  downstream backpressure.
- o_bits_vld  out  1  packed word valid.
- o_bits_data  out  32  packed edge bits; bit k = pixel (word_base+k).
- o_bits_cnt  out  6  valid bits in word, 1..32.
- o_bits_last  out  1  word closes a row.
- o_frame_done  out  1  one-cycle pulse after the frame's final word is accepted.

Behaviour:
- Handshake
  - A transfer occurs on a rising edge where vld=1 and busy=0, on both the input and output sides.
  - Output holds data/cnt/last stable while vld=1 and busy=1.
  - o_bits_vld deasserts only after acceptance.
- Reset values
  - i_mag_busy=0, o_bits_vld=0, o_bits_data=0, o_bits_cnt=0, o_bits_last=0, o_frame_done=0.
  - col=0, row=0, accumulator=0, bit index=0.
  - Threshold latch = 0.
- Threshold latch
  - i_thresh is captured in the same cycle the first pixel of a frame (col=0, row=0) is accepted.
  - That captured value applies to that pixel and to the whole frame.
  - Changes to i_thresh mid-frame are ignored until the next frame.
- Edge flag: edge = (mag >= threshold), unsigned 32-bit compare.
- Pixel accept
  - The flag is written into accumulator bit[idx]; idx and col increment.
- Word close
  - Occurs when idx reaches 31 or col = IMG_W-1.
  - The accumulator (including the current bit) loads the output register with cnt=idx+1 and last=(col==IMG_W-1).
  - Unused upper bits are 0.
  - The accumulator clears, idx resets to 0, and the output becomes valid on the next cycle (latency 1).
- Counters
  - At row end: col←0, row←row+1.
  - At frame end (row=IMG_H-1, col=IMG_W-1): row←0.
- Backpressure
  - i_mag_busy = o_bits_vld & o_bits_busy (combinational).
  - Input is stalled whenever the output register is occupied and not draining.
  - Simultaneous output acceptance and word close in the same cycle: the output register reloads, giving full throughput of 1 pixel/cycle with no bubble.
- Frame done
  - Internal flag set on closing the last word of the last row.
  - o_frame_done pulses for 1 cycle on the cycle after that word is accepted downstream.
- Reset mid-operation: the partial word and any pending output word are discarded; the next pixel is treated as col 0, row 0.
- Edge case IMG_W=1: every word has cnt=1 and last=1.
- No internal state machine beyond the counters plus the output-valid and frame-pending flags. Design is two-state: RUN, and HOLD (output occupied).

Decomposition:
- Shared package sobel_pkg holds:
  - WORD_W=32, MAG_W=32, CNT_W=6.
  - Packed struct edge_word_t {data, cnt, last}.
- Natural sub-module: p2p_out_reg, a single-entry vld/busy holding register with a load-while-drain path, reusable by other stages.

Test Plan:
1. Reset: hold i_rst=0 mid-stream → all outputs 0 within the same cycle. Release: first accepted pixel is col 0.
2. IMG_W=40, IMG_H=1, thresh=100, mags alternating 100,99:
   - first word data=0x55555555, cnt=32, last=0
   - second word data=0x00000055, cnt=8, last=1
   - o_frame_done pulses 1 cycle after the second word is accepted.
3. Backpressure: o_bits_busy=1 for 5 cycles while a word is pending → o_bits_data stable, i_mag_busy=1, no pixel dropped. After release, the next word bits match the golden model.
4. Streaming, busy=0, IMG_W=64, IMG_H=2, 128 pixels all 0xFFFFFFFF with thresh=0 → 4 words 0xFFFFFFFF, last on words 2 and 4, one o_frame_done, zero input stall cycles.
5. Threshold changed from 100 to 0 after pixel 10 of the frame → remaining pixels still use 100. The next frame uses 0.
6. Reset asserted after 10 pixels of row 0 → no word is emitted for those pixels. The subsequent 40 pixels produce words with last set at the 40th (IMG_W=40).
